serial_adder_ctrl: RTL and testbench

- Bit-serial add/subtract engine: one `full_adder` cell instance, time-shared across all bit positions, LSB first.
- FSM sequences the cell over WIDTH clocks, keeps the carry in a flop and assembles the result in a shift register.
- start/busy/done handshake to the host; registered result, carry and overflow flags.
- Area-optimised alternative to a WIDTH-bit ripple adder for slow control paths.

---
 rtl/serial_adder_ctrl.sv | 172 +++++++++++++++++
 tb/tb_serial_adder_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// serial_adder_ctrl
//   Bit-serial add/subtract engine. A single full_adder cell is time-shared
//   over all bit positions, LSB first, one bit per clock. An IDLE/RUN/DONE
//   FSM sequences the cell, keeps the running carry in a flop and assembles
//   the answer in a shift register. The result and flags are registered and
//   only updated on the completion edge.
//
// Handshake: start is sampled only in IDLE. Operands and op_sub are captured
//   on that edge. busy is high in RUN and DONE. done pulses for exactly one
//   cycle, WIDTH clocks after the capture edge. start while busy is ignored.
//
// Ports
//   clk       in   rising-edge clock
//   rst_n     in   synchronous reset, active-low
//   start     in   operation request (sampled in IDLE only)
//   op_sub    in   0 = a+b, 1 = a-b (captured with start)
//   a, b      in   WIDTH-bit operands (captured with start)
//   busy      out  high in RUN and DONE
//   done      out  one-cycle completion pulse
//   result    out  WIDTH-bit sum/difference, held until the next completion
//   c_out     out  final carry (subtract: 1 = no borrow)
//   overflow  out  signed overflow
// ---------------------------------------------------------------------------

// Single-bit full adder: the only arithmetic in the engine.
//   a, b, c_in  in   addend bits and carry in
//   sum, c_out  out  sum bit and carry out
module full_adder (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic sum,
  output logic c_out
);
  assign sum   = a ^ b ^ c_in;
  assign c_out = (a & b) | (c_in & (a ^ b));
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             c_out,
  output logic             overflow
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Counter value seen on the edge that processes the MSB.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_e             state_q,    state_d;
  logic [WIDTH-1:0]   sa_q,       sa_d;
  logic [WIDTH-1:0]   sb_q,       sb_d;
  logic [WIDTH-1:0]   sr_q,       sr_d;
  logic               carry_q,    carry_d;
  logic [CNT_W-1:0]   cnt_q,      cnt_d;
  logic [WIDTH-1:0]   result_q,   result_d;
  logic               c_out_q,    c_out_d;
  logic               overflow_q, overflow_d;

  logic fa_sum;
  logic fa_cout;

  // The one shared cell: always looks at the current LSBs and carry flop.
  full_adder u_fa (
    .a     (sa_q[0]),
    .b     (sb_q[0]),
    .c_in  (carry_q),
    .sum   (fa_sum),
    .c_out (fa_cout)
  );

  always_comb begin
    state_d    = state_q;
    sa_d       = sa_q;
    sb_d       = sb_q;
    sr_d       = sr_q;
    carry_d    = carry_q;
    cnt_d      = cnt_q;
    result_d   = result_q;
    c_out_d    = c_out_q;
    overflow_d = overflow_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          sa_d = a;
          // Subtraction is a + ~b + 1: invert B here, the +1 rides in
          // as the initial carry.
          sb_d    = op_sub ? ~b : b;
          carry_d = op_sub;
          cnt_d   = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        sa_d    = {1'b0, sa_q[WIDTH-1:1]};
        sb_d    = {1'b0, sb_q[WIDTH-1:1]};
        sr_d    = {fa_sum, sr_q[WIDTH-1:1]};
        carry_d = fa_cout;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          // MSB edge: carry_q is the carry into the MSB, so signed
          // overflow is carry-in XOR carry-out of the top bit.
          result_d   = {fa_sum, sr_q[WIDTH-1:1]};
          c_out_d    = fa_cout;
          overflow_d = carry_q ^ fa_cout;
          state_d    = DONE;
        end
      end

      DONE: begin
        // start is deliberately ignored here; a new request must be
        // presented in IDLE.
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sa_q       <= '0;
      sb_q       <= '0;
      sr_q       <= '0;
      carry_q    <= 1'b0;
      cnt_q      <= '0;
      result_q   <= '0;
      c_out_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sa_q       <= sa_d;
      sb_q       <= sb_d;
      sr_q       <= sr_d;
      carry_q    <= carry_d;
      cnt_q      <= cnt_d;
      result_q   <= result_d;
      c_out_q    <= c_out_d;
      overflow_q <= overflow_d;
    end
  end

  // Status decodes straight from the state register, so they are glitch-free
  // and change only on clock edges.
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign result   = result_q;
  assign c_out    = c_out_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// tb_serial_adder_ctrl
//   Directed plus a few random operations on serial_adder_ctrl (WIDTH=8).
//   Expected {overflow, c_out, result} words are pushed to exp_q when an
//   operation is started and popped when done is observed.
// ---------------------------------------------------------------------------
module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         op_sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         c_out;
  logic         overflow;

  int checks = 0;
  int errors = 0;

  // {overflow, c_out, result}
  logic [W+1:0] exp_q[$];
  logic [W+1:0] last_res;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op_sub   (op_sub),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .c_out    (c_out),
    .overflow (overflow)
  );

  // ---------------- clock / reset helpers ----------------
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // Advance one active edge, then settle so outputs are sampled off-edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Independent reference: plain wide arithmetic, overflow from operand signs.
  function automatic logic [W+1:0] model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                         input logic sub);
    logic [W-1:0] bb;
    logic [W:0]   s;
    logic         ovf;
    bb  = sub ? ~bv : bv;
    s   = {1'b0, av} + {1'b0, bb} + {{W{1'b0}}, sub};
    ovf = (av[W-1] == bb[W-1]) && (s[W-1] != av[W-1]);
    return {ovf, s[W], s[W-1:0]};
  endfunction

  task automatic check_completion(input string tag);
    logic [W+1:0] e;
    check({tag, "_done"}, done, 1);
    check({tag, "_busy"}, busy, 1);
    if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, 1, 0);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_result"}, result, e[W-1:0]);
      check({tag, "_c_out"}, c_out, e[W]);
      check({tag, "_overflow"}, overflow, e[W+1]);
      last_res = e;
    end
  endtask

  // ---------------- driver ----------------
  // Runs one full operation: capture edge, WIDTH run edges, return to IDLE.
  // Operands are scrambled right after capture; held outputs are checked
  // every run cycle.
  task automatic do_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic sub, input logic [W+1:0] exp);
    a = av; b = bv; op_sub = sub; start = 1'b1;
    exp_q.push_back(exp);
    tick();                                   // E0
    start  = 1'b0;
    a      = W'($urandom_range(0, 255));
    b      = W'($urandom_range(0, 255));
    op_sub = 1'($urandom_range(0, 1));
    for (int k = 1; k <= W; k++) begin
      if (k < W) begin
        check({tag, "_busy_run"}, busy, 1);
        check({tag, "_done_early"}, done, 0);
        check({tag, "_hold_run"}, {overflow, c_out, result}, last_res);
      end
      tick();                                 // E1..E_W
    end
    check_completion(tag);
    tick();                                   // E_W+1
    check({tag, "_done_drop"}, done, 0);
    check({tag, "_busy_drop"}, busy, 0);
    check({tag, "_hold_idle"}, {overflow, c_out, result}, last_res);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rs;
    logic         seen;

    rst_n = 1'b0; start = 1'b0; op_sub = 1'b0; a = '0; b = '0;
    last_res = '0;
    tick(); tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_c_out", c_out, 0);
    check("rst_overflow", overflow, 0);
    rst_n = 1'b1;
    tick();

    // Directed arithmetic cases with hand-computed answers.
    do_op("add_3c_15", 8'h3C, 8'h15, 1'b0, {1'b0, 1'b0, 8'h51});
    do_op("add_ff_01", 8'hFF, 8'h01, 1'b0, {1'b0, 1'b1, 8'h00});
    do_op("add_7f_01", 8'h7F, 8'h01, 1'b0, {1'b1, 1'b0, 8'h80});
    do_op("sub_10_20", 8'h10, 8'h20, 1'b1, {1'b0, 1'b0, 8'hF0});
    do_op("sub_80_01", 8'h80, 8'h01, 1'b1, {1'b1, 1'b1, 8'h7F});

    // Idle cycles: outputs hold.
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_idle_gap", {overflow, c_out, result}, last_res);
    end

    // Random operations against the arithmetic model.
    for (int i = 0; i < 6; i++) begin
      ra = W'($urandom_range(0, 255));
      rb = W'($urandom_range(0, 255));
      rs = 1'($urandom_range(0, 1));
      do_op("rand", ra, rb, rs, model(ra, rb, rs));
    end

    // Back-to-back with start held high; start/operand changes during RUN
    // and DONE must be ignored.
    a = 8'h3C; b = 8'h15; op_sub = 1'b0; start = 1'b1;
    exp_q.push_back({1'b0, 1'b0, 8'h51});
    tick();                                   // E0
    for (int k = 1; k <= W; k++) begin
      a = W'($urandom_range(0, 255));
      b = W'($urandom_range(0, 255));
      op_sub = 1'($urandom_range(0, 1));
      if (k < W) check("b2b_done_early", done, 0);
      tick();
    end
    check_completion("b2b_first");          // after E8
    a = 8'hA5; b = 8'h5A; op_sub = 1'b1;
    exp_q.push_back(model(8'hA5, 8'h5A, 1'b1));
    tick();                                   // E9: DONE -> IDLE, start ignored
    check("b2b_idle_gap_busy", busy, 0);
    check("b2b_idle_gap_done", done, 0);
    tick();                                   // E10: second capture
    check("b2b_second_captured", busy, 1);
    a = 8'h00; b = 8'h00; op_sub = 1'b0;
    for (int k = 1; k <= W; k++) begin
      if (k < W) begin
        check("b2b2_done_early", done, 0);
        check("b2b2_hold", {overflow, c_out, result}, last_res);
      end
      tick();
    end
    check_completion("b2b_second");
    start = 1'b0;
    tick();
    check("b2b_end_busy", busy, 0);

    // Reset in the middle of an operation.
    a = 8'h3C; b = 8'h15; op_sub = 1'b0; start = 1'b1;
    tick();                                   // E0
    start = 1'b0;
    tick(); tick(); tick();                   // E1..E3
    rst_n = 1'b0;
    tick();                                   // E4 with reset
    rst_n = 1'b1;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_result", result, 0);
    check("midrst_c_out", c_out, 0);
    check("midrst_overflow", overflow, 0);
    last_res = '0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done) seen = 1'b1;
    end
    check("midrst_no_done", seen, 0);
    do_op("after_rst", 8'h3C, 8'h15, 1'b0, {1'b0, 1'b0, 8'h51});

    check("queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
